valid_fifo: RTL and testbench

VALID_FIFO -- requirements
Module: valid_fifo

---
 rtl/fifo_mem.sv | 24 ++
 rtl/valid_fifo.sv | 78 +++++++
 tb/tb_valid_fifo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fifo_mem.sv
// Storage array for valid_fifo: one synchronous write port, one asynchronous
// read port, no reset, so it can map onto distributed RAM.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_c
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_c = mem[rd_addr_i];

endmodule

// File: rtl/valid_fifo.sv
// Show-ahead FIFO for a valid-only upstream: drops writes when full and
// flags the loss with a sticky overflow bit; almost_full is a throttle hint.
module valid_fifo #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AFULL_LEVEL = DEPTH - 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [DATA_WIDTH-1:0]      in_data_i,
  input  logic                       in_valid_i,
  output logic [DATA_WIDTH-1:0]      out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       almost_full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_nxt;
  logic          valid_q, afull_q, ovf_q;
  logic          rd_c, wr_c, drop_c;

  // Accept/read decisions; a full queue still accepts when a read frees a slot.
  always_comb begin
    rd_c      = valid_q & out_ready_i;
    wr_c      = in_valid_i & ((count_q != CW'(DEPTH)) | rd_c);
    drop_c    = in_valid_i & ~wr_c;
    count_nxt = count_q;
    unique case ({wr_c, rd_c})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Flags are computed from the next count so they line up with count_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_nxt;
      valid_q <= (count_nxt != '0);
      afull_q <= (count_nxt >= CW'(AFULL_LEVEL));
      if (drop_c) ovf_q <= 1'b1;
    end
  end

  // Memory writes are gated so nothing lands in the array while reset is held.
  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i      (clk_i),
    .wr_en_i    (wr_c & rst_n_i),
    .wr_addr_i  (wr_ptr_q),
    .wr_data_i  (in_data_i),
    .rd_addr_i  (rd_ptr_q),
    .rd_data_c  (out_data_o)
  );

  assign out_valid_o   = valid_q;
  assign count_o       = count_q;
  assign almost_full_o = afull_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_valid_fifo.sv
// Directed bench for valid_fifo (DEPTH=8, AFULL_LEVEL=6): fill/drain,
// overflow, full read+write, wrap-around, empty read, reset mid-run.
module tb_valid_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [DW-1:0] in_data_i;
  logic          in_valid_i;
  logic [DW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          almost_full_o;
  logic [3:0]    count_o;
  logic          overflow_o;

  int n_cmp = 0;
  int n_err = 0;

  valid_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (6)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .in_data_i     (in_data_i),
    .in_valid_i    (in_valid_i),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .almost_full_o (almost_full_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] seq [8];

  initial begin
    rst_n_i     = 1'b0;
    in_data_i   = '0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    step();
    in_valid_i = 1'b1;
    in_data_i  = 32'hDEAD;
    step();
    chk_eq("rst_count", 32'(count_o), 32'd0);
    chk_eq("rst_valid", 32'(out_valid_o), 32'd0);
    chk_eq("rst_afull", 32'(almost_full_o), 32'd0);
    chk_eq("rst_ovf", 32'(overflow_o), 32'd0);
    in_valid_i = 1'b0;
    rst_n_i    = 1'b1;
    step();
    chk_eq("rst_release_count", 32'(count_o), 32'd0);

    // fill 0x01..0x08 with no reads
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 32'(i);
      step();
      chk_eq($sformatf("fill_count%0d", i), 32'(count_o), 32'(i));
      chk_eq($sformatf("fill_afull%0d", i), 32'(almost_full_o), (i >= 6) ? 32'd1 : 32'd0);
      chk_eq($sformatf("fill_ovf%0d", i), 32'(overflow_o), 32'd0);
    end
    chk_eq("fill_head", out_data_o, 32'h01);
    chk_eq("fill_valid", 32'(out_valid_o), 32'd1);

    // overflow: 0xAA dropped
    in_data_i = 32'hAA;
    step();
    chk_eq("ovf_count", 32'(count_o), 32'd8);
    chk_eq("ovf_flag", 32'(overflow_o), 32'd1);
    chk_eq("ovf_head", out_data_o, 32'h01);
    in_valid_i = 1'b0;
    step();
    chk_eq("ovf_sticky", 32'(overflow_o), 32'd1);
    chk_eq("ovf_count2", 32'(count_o), 32'd8);

    // full with simultaneous read and write of 0x55
    in_valid_i  = 1'b1;
    in_data_i   = 32'h55;
    out_ready_i = 1'b1;
    chk_eq("rw_head", out_data_o, 32'h01);
    step();
    in_valid_i = 1'b0;
    chk_eq("rw_count", 32'(count_o), 32'd8);
    chk_eq("rw_afull", 32'(almost_full_o), 32'd1);

    // drain: 0x02..0x08 then 0x55; 0xAA must never appear
    for (int k = 0; k < 7; k++) seq[k] = 32'(k + 2);
    seq[7] = 32'h55;
    for (int k = 0; k < 8; k++) begin
      chk_eq($sformatf("drain_data%0d", k), out_data_o, seq[k]);
      chk_eq($sformatf("drain_valid%0d", k), 32'(out_valid_o), 32'd1);
      step();
      chk_eq($sformatf("drain_count%0d", k), 32'(count_o), 32'(7 - k));
    end
    chk_eq("drain_empty", 32'(out_valid_o), 32'd0);
    chk_eq("drain_afull", 32'(almost_full_o), 32'd0);
    chk_eq("drain_ovf", 32'(overflow_o), 32'd1);

    // empty read: ready already high, write 0x77
    in_valid_i = 1'b1;
    in_data_i  = 32'h77;
    step();
    in_valid_i = 1'b0;
    chk_eq("empty_valid", 32'(out_valid_o), 32'd1);
    chk_eq("empty_data", out_data_o, 32'h77);
    chk_eq("empty_count", 32'(count_o), 32'd1);
    step();
    chk_eq("empty_count2", 32'(count_o), 32'd0);
    chk_eq("empty_valid2", 32'(out_valid_o), 32'd0);

    // wrap-around: 20 writes with continuous reads
    for (int i = 0; i < 20; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 32'(32'h10 + i);
      step();
      chk_eq($sformatf("wrap_data%0d", i), out_data_o, 32'(32'h10 + i));
      chk_eq($sformatf("wrap_count%0d", i), 32'(count_o), 32'd1);
    end
    in_valid_i = 1'b0;
    step();
    chk_eq("wrap_end_count", 32'(count_o), 32'd0);

    // reset mid-run with 5 queued and overflow set
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 32'(32'hA0 + i);
      step();
    end
    in_valid_i = 1'b0;
    chk_eq("mid_count", 32'(count_o), 32'd5);
    chk_eq("mid_ovf", 32'(overflow_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    chk_eq("mid_rst_count", 32'(count_o), 32'd0);
    chk_eq("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk_eq("mid_rst_ovf", 32'(overflow_o), 32'd0);
    #1 rst_n_i = 1'b1;
    step();
    in_valid_i = 1'b1;
    in_data_i  = 32'h99;
    step();
    in_valid_i = 1'b0;
    chk_eq("post_rst_valid", 32'(out_valid_o), 32'd1);
    chk_eq("post_rst_data", out_data_o, 32'h99);
    chk_eq("post_rst_count", 32'(count_o), 32'd1);
    out_ready_i = 1'b1;
    step();
    chk_eq("post_rst_drain", 32'(count_o), 32'd0);
    chk_eq("post_rst_empty", 32'(out_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
